jtag_chain_arbiter: RTL and testbench

JTAG_CHAIN_ARBITER -- requirements
Module: jtag_chain_arbiter

---
 rtl/jtag_chain_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_jtag_chain_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_chain_arbiter.sv
// JTAG chain arbiter: grants the scan chain to the AMC or front connector master.
// Optional contention counter enabled by defining JTAG_ARB_CONTENTION_CNT_EN.
module jtag_chain_arbiter #(
    parameter int IDLE_CYCLES     = 50000,
    parameter int GUARD_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       amc_tck,
    input  logic       con_tck,
    input  logic       force_en,
    input  logic       force_con,
    input  logic       fmc0_prsnt_b,
    input  logic       fmc1_prsnt_b,
    output logic       sel_con,
    output logic       chain_en,
    output logic       fmc0_in_chain,
    output logic       fmc1_in_chain,
    output logic [1:0] state_o,
    output logic [7:0] contention_cnt
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_AMC = 2'd1,
        OWN_CON = 2'd2,
        GUARD   = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] guard_cnt;
    logic          force_q;

    // Two flops resynchronize, the third holds last level for edge detection
    logic [2:0] amc_sync;
    logic [2:0] con_sync;
    logic       amc_edge;
    logic       con_edge;
    logic       owner_edge;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            amc_sync <= '0;
            con_sync <= '0;
        end else begin
            amc_sync <= {amc_sync[1:0], amc_tck};
            con_sync <= {con_sync[1:0], con_tck};
        end
    end

    assign amc_edge   = amc_sync[1] & ~amc_sync[2];
    assign con_edge   = con_sync[1] & ~con_sync[2];
    assign owner_edge = (state == OWN_CON) ? con_edge : amc_edge;

    logic [1:0] prsnt_raw;
    logic [1:0] prsnt_deb;

    assign prsnt_raw = {fmc1_prsnt_b, fmc0_prsnt_b};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [1:0]    sync;
        logic [DW-1:0] cnt;
        logic          deb;

        always_ff @(posedge clk100 or posedge rst) begin
            if (rst) begin
                sync <= '0;
                cnt  <= '0;
                deb  <= 1'b1;
            end else begin
                sync <= {sync[0], prsnt_raw[i]};
                if (sync[1] == deb) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    deb <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign prsnt_deb[i] = deb;
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idle_cnt      <= '0;
            guard_cnt     <= '0;
            force_q       <= 1'b0;
            sel_con       <= 1'b0;
            chain_en      <= 1'b0;
            fmc0_in_chain <= 1'b0;
            fmc1_in_chain <= 1'b0;
        end else begin
            force_q <= force_en;
            // Topology only follows presence while nobody owns the chain
            if (state == IDLE) begin
                fmc0_in_chain <= ~prsnt_deb[0];
                fmc1_in_chain <= ~prsnt_deb[1];
            end
            if (force_en) begin
                state     <= force_con ? OWN_CON : OWN_AMC;
                sel_con   <= force_con;
                chain_en  <= 1'b1;
                idle_cnt  <= '0;
                guard_cnt <= '0;
            end else if (force_q) begin
                state     <= GUARD;
                chain_en  <= 1'b0;
                idle_cnt  <= '0;
                guard_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        idle_cnt  <= '0;
                        guard_cnt <= '0;
                        if (amc_edge) begin
                            state    <= OWN_AMC;
                            sel_con  <= 1'b0;
                            chain_en <= 1'b1;
                        end else if (con_edge) begin
                            state    <= OWN_CON;
                            sel_con  <= 1'b1;
                            chain_en <= 1'b1;
                        end
                    end
                    OWN_AMC, OWN_CON: begin
                        guard_cnt <= '0;
                        if (owner_edge) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            state    <= GUARD;
                            chain_en <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    GUARD: begin
                        idle_cnt <= '0;
                        if (guard_cnt == GUARD_LAST) begin
                            state     <= IDLE;
                            guard_cnt <= '0;
                        end else begin
                            guard_cnt <= guard_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign state_o = state;

`ifdef JTAG_ARB_CONTENTION_CNT_EN
    logic [7:0] cont_q;
    logic       foreign_edge;

    assign foreign_edge = ((state == OWN_AMC) && con_edge) ||
                          ((state == OWN_CON) && amc_edge);

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            cont_q <= '0;
        end else if (foreign_edge && (cont_q != 8'hFF)) begin
            cont_q <= cont_q + 1'b1;
        end
    end

    assign contention_cnt = cont_q;
`else
    assign contention_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtag_chain_arbiter.sv
// Directed bench for jtag_chain_arbiter with shortened timeout and debounce.
module tb_jtag_chain_arbiter;

    logic       clk100 = 1'b0;
    logic       rst;
    logic       amc_gen;
    logic       amc_man;
    logic       amc_tck;
    logic       con_tck;
    logic       force_en;
    logic       force_con;
    logic       fmc0_prsnt_b;
    logic       fmc1_prsnt_b;
    logic       sel_con;
    logic       chain_en;
    logic       fmc0_in_chain;
    logic       fmc1_in_chain;
    logic [1:0] state_o;
    logic [7:0] contention_cnt;
    bit         amc_run = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

`ifdef JTAG_ARB_CONTENTION_CNT_EN
    localparam int EXP_CONT = 255;
`else
    localparam int EXP_CONT = 0;
`endif

    jtag_chain_arbiter #(
        .IDLE_CYCLES(100),
        .GUARD_CYCLES(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk100(clk100),
        .rst(rst),
        .amc_tck(amc_tck),
        .con_tck(con_tck),
        .force_en(force_en),
        .force_con(force_con),
        .fmc0_prsnt_b(fmc0_prsnt_b),
        .fmc1_prsnt_b(fmc1_prsnt_b),
        .sel_con(sel_con),
        .chain_en(chain_en),
        .fmc0_in_chain(fmc0_in_chain),
        .fmc1_in_chain(fmc1_in_chain),
        .state_o(state_o),
        .contention_cnt(contention_cnt)
    );

    always #5 clk100 = ~clk100;

    assign amc_tck = amc_gen | amc_man;

    // 10 MHz AMC TCK, phase-offset so its edges never meet a clk100 edge
    initial begin
        amc_gen = 1'b0;
        #3;
        forever begin
            #50;
            amc_gen = amc_run ? ~amc_gen : 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s,
                              input int budget);
        int k = 0;
        while (state_o !== s && k < budget) begin
            @(negedge clk100);
            k++;
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic count_state(input logic [1:0] s, output int cnt);
        cnt = 0;
        while (state_o === s && cnt < 1000) begin
            cnt++;
            @(negedge clk100);
        end
    endtask

    initial begin
        rst          = 1'b1;
        amc_man      = 1'b0;
        con_tck      = 1'b0;
        force_en     = 1'b0;
        force_con    = 1'b0;
        fmc0_prsnt_b = 1'b0;
        fmc1_prsnt_b = 1'b1;
        repeat (3) @(negedge clk100);
        check("rst_state", 32'(state_o), 0);
        check("rst_sel", 32'(sel_con), 0);
        check("rst_chain", 32'(chain_en), 0);
        check("rst_fmc0", 32'(fmc0_in_chain), 0);
        check("rst_fmc1", 32'(fmc1_in_chain), 0);
        check("rst_cont", 32'(contention_cnt), 0);

        rst = 1'b0;
        repeat (20) @(negedge clk100);
        check("idle_state", 32'(state_o), 0);
        check("idle_fmc0", 32'(fmc0_in_chain), 1);
        check("idle_fmc1", 32'(fmc1_in_chain), 0);

        // both masters start in the same cycle
        amc_man = 1'b1;
        con_tck = 1'b1;
        repeat (4) @(negedge clk100);
        check("simul_state", 32'(state_o), 1);
        check("simul_sel", 32'(sel_con), 0);
        check("simul_chain", 32'(chain_en), 1);
        amc_man = 1'b0;
        con_tck = 1'b0;
        @(negedge clk100);

        force_en  = 1'b1;
        force_con = 1'b1;
        @(negedge clk100);
        check("force_state", 32'(state_o), 2);
        check("force_sel", 32'(sel_con), 1);
        force_en  = 1'b0;
        force_con = 1'b0;
        @(negedge clk100);
        check("unforce_state", 32'(state_o), 3);
        check("unforce_chain", 32'(chain_en), 0);
        count_state(2'd3, n);
        check("guard_len_a", 32'(n), 16);
        check("guard_end_a", 32'(state_o), 0);
        check("guard_sel_a", 32'(sel_con), 1);

        // connector grant, presence change while owned, then timeout
        con_tck = 1'b1;
        wait_state("con_grant", 2'd2, 10);
        con_tck = 1'b0;
        n = 0;
        while (state_o === 2'd2 && n < 1000) begin
            n++;
            if (n == 10) fmc1_prsnt_b = 1'b0;
            if (n == 60) check("fmc1_frozen", 32'(fmc1_in_chain), 0);
            @(negedge clk100);
        end
        check("own_con_len", 32'(n), 100);
        check("timeout_state", 32'(state_o), 3);
        check("guard_fmc1", 32'(fmc1_in_chain), 0);
        check("guard_sel_b", 32'(sel_con), 1);
        count_state(2'd3, n);
        check("guard_len_b", 32'(n), 16);
        @(negedge clk100);
        check("post_state", 32'(state_o), 0);
        check("post_fmc1", 32'(fmc1_in_chain), 1);
        check("post_fmc0", 32'(fmc0_in_chain), 1);
        check("post_sel", 32'(sel_con), 1);

        amc_run = 1'b1;
        @(posedge amc_tck);
        repeat (4) @(negedge clk100);
        check("amc_grant", 32'(state_o), 1);
        check("amc_sel", 32'(sel_con), 0);
        check("amc_chain", 32'(chain_en), 1);

        repeat (300) begin
            con_tck = 1'b1;
            #50;
            con_tck = 1'b0;
            #50;
        end
        @(negedge clk100);
        check("cont_state", 32'(state_o), 1);
        check("cont_cnt", 32'(contention_cnt), 32'(EXP_CONT));

        force_en  = 1'b1;
        force_con = 1'b1;
        @(negedge clk100);
        check("force2_state", 32'(state_o), 2);
        check("force2_sel", 32'(sel_con), 1);

        // reset between clock edges must drop the chain at once
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_chain", 32'(chain_en), 0);
        check("rst2_state", 32'(state_o), 0);
        check("rst2_sel", 32'(sel_con), 0);
        check("rst2_fmc0", 32'(fmc0_in_chain), 0);
        check("rst2_fmc1", 32'(fmc1_in_chain), 0);
        check("rst2_cont", 32'(contention_cnt), 0);
        force_en  = 1'b0;
        force_con = 1'b0;
        amc_run   = 1'b0;
        repeat (3) @(negedge clk100);
        rst = 1'b0;
        repeat (2) @(negedge clk100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
